// File: rtl/cifra_bloco_iterativa.sv
// cifra_bloco_iterativa: iterative AES-128 encryption engine. It takes one (bloco, chave)
// pair per handshake, runs RODADAS_POR_CICLO rounds per clock and queues the ciphertexts
// in a small output FIFO.
// Optional CBC chaining (iv / iv_carrega ports) is compiled in when MODO_CBC_EN is defined.
module cifra_bloco_iterativa #(
    parameter int unsigned RODADAS_POR_CICLO = 1,
    parameter int unsigned PROF_SAIDA        = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] bloco,
    input  logic [127:0] chave,
    output logic [127:0] saida,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef MODO_CBC_EN
    input  logic [127:0] iv,
    input  logic         iv_carrega,
`endif
    output logic         ocupado
);

    if (!(RODADAS_POR_CICLO == 1 || RODADAS_POR_CICLO == 2 || RODADAS_POR_CICLO == 5))
    begin : g_rpc_invalido
        $error("RODADAS_POR_CICLO must be 1, 2 or 5");
    end
    if (PROF_SAIDA < 1 || PROF_SAIDA > 4) begin : g_prof_invalida
        $error("PROF_SAIDA must be in 1..4");
    end

    typedef enum logic {OCIOSO, RODANDO} estado_t;
    typedef logic [10:0][127:0] chaves_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
               {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes + ShiftRows; byte (row l, column c) sits at index l + 4c from the MSB
    function automatic logic [127:0] sub_desloca(input logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 4; l++) begin
                r[127-8*(l+4*c) -: 8] = sbox(st[127-8*(l+4*((c+l)%4)) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mistura(input logic [127:0] st);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = st[127-32*c -: 8];
            a1 = st[119-32*c -: 8];
            a2 = st[111-32*c -: 8];
            a3 = st[103-32*c -: 8];
            r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    // Full rounds 1..9
    function automatic logic [127:0] miolo_cifra_bloco(input logic [127:0] st,
                                                       input logic [127:0] rk);
        return mistura(sub_desloca(st)) ^ rk;
    endfunction

    // All 11 round keys from the cipher key
    function automatic chaves_t expande_chave(input logic [127:0] k);
        chaves_t     rk;
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rcon;
        w0    = k[127:96];
        w1    = k[95:64];
        w2    = k[63:32];
        w3    = k[31:0];
        rk    = '0;
        rk[0] = k;
        rcon  = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            t     = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
                    {rcon, 24'h000000};
            w0    = w0 ^ t;
            w1    = w1 ^ w0;
            w2    = w2 ^ w1;
            w3    = w3 ^ w2;
            rk[i] = {w0, w1, w2, w3};
            rcon  = xtime(rcon);
        end
        return rk;
    endfunction

    estado_t      r_fsm;
    logic [3:0]   r_rodada;
    logic [127:0] r_estado, r_chave;
    logic [127:0] r_mem [4];
    logic [1:0]   r_wr, r_rd;
    logic [2:0]   r_count;

    chaves_t      w_chaves;
    logic [127:0] w_estado_prox, w_entrada;
    logic [3:0]   w_idx;
    logic         w_final, w_aceita, w_push, w_pop;

    function automatic logic [1:0] avanca(input logic [1:0] p);
        return (p == 2'(PROF_SAIDA - 1)) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef MODO_CBC_EN
    logic [127:0] r_encad, w_encad;
    // A load on the accept clock wins over the stored chaining value
    assign w_encad   = iv_carrega ? iv : r_encad;
    assign w_entrada = bloco ^ chave ^ w_encad;
`else
    assign w_entrada = bloco ^ chave;
`endif

    assign w_chaves  = expande_chave(r_chave);
    assign in_ready  = rst_n && (r_fsm == OCIOSO) && (r_count != 3'(PROF_SAIDA));
    assign w_aceita  = in_valid && in_ready;
    assign w_push    = (r_fsm == RODANDO) && w_final;
    assign out_valid = (r_count != 3'd0);
    assign w_pop     = out_valid && out_ready;
    assign saida     = out_valid ? r_mem[r_rd] : '0;
    assign ocupado   = (r_fsm == RODANDO);

    // Chain the rounds applied this clock; round 10 skips MixColumns
    always_comb begin
        w_final       = 1'b0;
        w_estado_prox = r_estado;
        w_idx         = r_rodada;
        for (int j = 0; j < RODADAS_POR_CICLO; j++) begin
            w_idx = r_rodada + 4'(j);
            if (w_idx == 4'd10) begin
                w_estado_prox = sub_desloca(w_estado_prox) ^ w_chaves[w_idx];
                w_final       = 1'b1;
            end else begin
                w_estado_prox = miolo_cifra_bloco(w_estado_prox, w_chaves[w_idx]);
            end
        end
    end

    // Control FSM: accept in OCIOSO, iterate in RODANDO, return once round 10 is pushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm    <= OCIOSO;
            r_rodada <= 4'd0;
            r_estado <= '0;
            r_chave  <= '0;
        end else begin
            case (r_fsm)
                OCIOSO: begin
                    if (w_aceita) begin
                        r_chave  <= chave;
                        r_estado <= w_entrada;
                        r_rodada <= 4'd1;
                        r_fsm    <= RODANDO;
                    end
                end
                RODANDO: begin
                    if (w_final) begin
                        r_rodada <= 4'd0;
                        r_fsm    <= OCIOSO;
                    end else begin
                        r_estado <= w_estado_prox;
                        r_rodada <= r_rodada + 4'(RODADAS_POR_CICLO);
                    end
                end
                default: r_fsm <= OCIOSO;
            endcase
        end
    end

`ifdef MODO_CBC_EN
    // Chaining register: iv load while idle, ciphertext on every push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_encad <= '0;
        end else if (w_push) begin
            r_encad <= w_estado_prox;
        end else if (r_fsm == OCIOSO && iv_carrega) begin
            r_encad <= iv;
        end
    end
`endif

    // FIFO pointers and occupancy; acceptance is gated on space so a push never overflows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 2'd0;
            r_rd    <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_wr <= avanca(r_wr);
            if (w_pop)  r_rd <= avanca(r_rd);
            r_count <= r_count + 3'(w_push) - 3'(w_pop);
        end
    end

    // FIFO storage; stale entries are masked by out_valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_estado_prox;
    end

endmodule
